mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
// - Parametrised multi-stage memory-pipeline register chain (MEM1..MEMn) for the split-memory RISC-V core.
// - Carries valid, memread, regwrite, rd and a data payload through DEPTH stages, with stall and flush.
// - Reports load-use hazards against the ID-stage source registers from every in-flight stage.
// - Generalises the fixed single MEM1->MEM2 register to arbitrary depth and payload width.
// PARAMETERS
// - DEPTH   2   number of register stages (>=1); latency in cycles
// - RD_W    5   register-index width
// - DATA_W  32  payload width (ALU result / address)
// PORTS
// - i_clk         in   1       clock; all state updates on rising edge
// - i_rst_n       in   1       synchronous reset, active-low
// - i_stall       in   1       hold all stages
// - i_flush       in   1       invalidate all stages
// - i_valid       in   1       input instruction valid
// - i_memread     in   1       input is a load
// - i_regwrite    in   1       input writes rd
// - i_rd          in   RD_W    destination register
// - i_data        in   DATA_W  payload
// - i_rs1         in   RD_W    ID-stage source 1, for hazard check
// - i_rs2         in   RD_W    ID-stage source 2, for hazard check
// - o_valid       out  1       last-stage valid
// - o_memread     out  1       last-stage memread, gated by valid
// - o_regwrite    out  1       last-stage regwrite, gated by valid
// - o_rd          out  RD_W    last-stage rd
// - o_data        out  DATA_W  last-stage payload
// - o_hazard      out  1       load-use hazard (combinational)
// - o_occupancy   out  $clog2(DEPTH+1)  count of valid stages (combinational from registers)
// BEHAVIOUR
// - Reset (i_rst_n=0 at edge): every stage's valid/memread/regwrite/rd/data = 0.
//   All outputs read 0 the next cycle. Reset overrides stall and flush.
// - Advance (no stall, no flush):
//   - stage0 <= inputs.
//   - stage k <= stage k-1.
//   - Last stage is visible on o_* : exactly DEPTH cycles after capture.
// - Bubble: i_valid=0 -> stage0 valid/memread/regwrite/rd/data all loaded as 0. Invalid stages always hold zero control.
// - Stall (i_stall=1, i_flush=0):
//   - Every stage holds its value; inputs are ignored (upstream holds them).
//   - o_* stay constant.
// - Flush (i_flush=1): all valid, memread and regwrite bits <- 0 at the edge.
//   - rd/data <- 0.
//   - Flush overrides stall; an input presented in the flush cycle is dropped.
// - o_hazard = OR over stages s of:
//   - valid[s] & memread[s] & (rd[s]!=0) & (rd[s]==i_rs1 | rd[s]==i_rs2).
//   - rd=x0 never raises hazard.
//   - Independent of i_stall/i_flush; reflects current register contents.
// - o_occupancy: popcount of stage valid bits, range 0..DEPTH.
// - DEPTH=1: single register, behaviour identical with no inter-stage shifting.
// CONFIGURATION
// - MEM_PIPE_PERF_EN defined: adds output o_stall_cnt [31:0].
//   - Increments each cycle with i_stall=1 & i_flush=0 & i_rst_n=1.
//   - Saturates at 32'hFFFF_FFFF.
//   - Cleared to 0 by reset; not cleared by flush.
// - MEM_PIPE_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset: hold i_rst_n=0 2 cycles with i_valid=1 -> o_valid=0, o_rd=0, o_occupancy=0.
// - Latency, DEPTH=2:
//   - Stimulus: valid load rd=5, data=32'hDEAD_BEEF at cycle 0.
//   - Response: o_valid=1, o_memread=1, o_rd=5, o_data=32'hDEADBEEF at cycle 2; o_occupancy 1,2,1 over cycles 1..3.
// - Stall: insert rd=7, stall 3 cycles from cycle 1 -> outputs frozen; rd=7 emerges at cycle 5; o_stall_cnt=3 when PERF_EN.
// - Flush with stall:
//   - Stimulus: pipe full; i_flush=1, i_stall=1, valid input rd=9.
//   - Response: next cycle occupancy=0, o_valid=0; rd=9 never appears.
// - Hazard:
//   - Load rd=3 in stage0 with i_rs2=3 -> o_hazard=1.
//   - Same with memread=0, or rd=0 with rs1=0 -> o_hazard=0.
// - Saturation (PERF_EN): force counter to 32'hFFFF_FFFE, stall 3 cycles -> o_stall_cnt=32'hFFFF_FFFF.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - DEPTH-stage memory pipeline register chain with stall, flush and load-use hazard detect
// Optional stall-cycle counter output o_stall_cnt when MEM_PIPE_PERF_EN is defined.
module mem_stage_pipe #(
  parameter int DEPTH  = 2,
  parameter int RD_W   = 5,
  parameter int DATA_W = 32,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_memread,
  input  logic              i_regwrite,
  input  logic [RD_W-1:0]   i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic [RD_W-1:0]   i_rs1,
  input  logic [RD_W-1:0]   i_rs2,
  output logic              o_valid,
  output logic              o_memread,
  output logic              o_regwrite,
  output logic [RD_W-1:0]   o_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard,
`ifdef MEM_PIPE_PERF_EN
  output logic [OCC_W-1:0]  o_occupancy,
  output logic [31:0]       o_stall_cnt
`else
  output logic [OCC_W-1:0]  o_occupancy
`endif
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  memread_q;
  logic [DEPTH-1:0]  regwrite_q;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Reset and flush both zero every field so invalid stages never carry stale control.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      valid_q    <= '0;
      memread_q  <= '0;
      regwrite_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        rd_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else if (!i_stall) begin
      valid_q[0]    <= i_valid;
      memread_q[0]  <= i_valid & i_memread;
      regwrite_q[0] <= i_valid & i_regwrite;
      rd_q[0]       <= i_valid ? i_rd : '0;
      data_q[0]     <= i_valid ? i_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k]    <= valid_q[k-1];
        memread_q[k]  <= memread_q[k-1];
        regwrite_q[k] <= regwrite_q[k-1];
        rd_q[k]       <= rd_q[k-1];
        data_q[k]     <= data_q[k-1];
      end
    end
  end

  assign o_valid    = valid_q[DEPTH-1];
  assign o_memread  = valid_q[DEPTH-1] & memread_q[DEPTH-1];
  assign o_regwrite = valid_q[DEPTH-1] & regwrite_q[DEPTH-1];
  assign o_rd       = rd_q[DEPTH-1];
  assign o_data     = data_q[DEPTH-1];

  always_comb begin
    o_hazard = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (valid_q[s] && memread_q[s] && (rd_q[s] != '0) &&
          ((rd_q[s] == i_rs1) || (rd_q[s] == i_rs2))) begin
        o_hazard = 1'b1;
      end
    end
  end

  always_comb begin
    o_occupancy = '0;
    for (int s = 0; s < DEPTH; s++) begin
      o_occupancy = o_occupancy + OCC_W'(valid_q[s]);
    end
  end

`ifdef MEM_PIPE_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts only true hold cycles; a flush cycle is not a stall even with i_stall high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (i_stall && !i_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb/tb_mem_stage_pipe.sv - randomized and directed bench for mem_stage_pipe at DEPTH=2 and DEPTH=1
// Exercises o_stall_cnt as well when MEM_PIPE_PERF_EN is defined.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid, memread, regwrite;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] data;

  logic        v2, mr2, rw2, hz2, v1, mr1, rw1, hz1;
  logic [4:0]  rd2, rd1;
  logic [31:0] d2, d1;
  logic [1:0]  occ2;
  logic        occ1;
`ifdef MEM_PIPE_PERF_EN
  logic [31:0] sc2, sc1;
`endif

  always #5 clk = ~clk;

  mem_stage_pipe #(.DEPTH(2), .RD_W(5), .DATA_W(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_memread(memread), .i_regwrite(regwrite),
    .i_rd(rd), .i_data(data), .i_rs1(rs1), .i_rs2(rs2),
    .o_valid(v2), .o_memread(mr2), .o_regwrite(rw2), .o_rd(rd2), .o_data(d2),
    .o_hazard(hz2),
`ifdef MEM_PIPE_PERF_EN
    .o_occupancy(occ2), .o_stall_cnt(sc2)
`else
    .o_occupancy(occ2)
`endif
  );

  mem_stage_pipe #(.DEPTH(1), .RD_W(5), .DATA_W(32)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_memread(memread), .i_regwrite(regwrite),
    .i_rd(rd), .i_data(data), .i_rs1(rs1), .i_rs2(rs2),
    .o_valid(v1), .o_memread(mr1), .o_regwrite(rw1), .o_rd(rd1), .o_data(d1),
    .o_hazard(hz1),
`ifdef MEM_PIPE_PERF_EN
    .o_occupancy(occ1), .o_stall_cnt(sc1)
`else
    .o_occupancy(occ1)
`endif
  );

  typedef struct packed {
    bit        v;
    bit        mr;
    bit        rw;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  // hist[0] is the youngest in-flight slot; a DEPTH=D pipe holds hist[0..D-1].
  ent_t        hist [$];
  bit   [31:0] cnt_m;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hazard(input int depth, input bit [4:0] a, input bit [4:0] b);
    for (int s = 0; s < depth; s++)
      if (hist[s].v && hist[s].mr && hist[s].rd != 0 && (hist[s].rd == a || hist[s].rd == b))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_occ(input int depth);
    int n = 0;
    for (int s = 0; s < depth; s++) n += int'(hist[s].v);
    return n;
  endfunction

  task automatic clear_model();
    ent_t z = '0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endtask

  task automatic check_all();
    check("d2_valid",    64'(v2),   64'(hist[1].v));
    check("d2_memread",  64'(mr2),  64'(hist[1].mr));
    check("d2_regwrite", 64'(rw2),  64'(hist[1].rw));
    check("d2_rd",       64'(rd2),  64'(hist[1].rd));
    check("d2_data",     64'(d2),   64'(hist[1].d));
    check("d2_hazard",   64'(hz2),  64'(model_hazard(2, rs1, rs2)));
    check("d2_occ",      64'(occ2), 64'(model_occ(2)));
    check("d1_valid",    64'(v1),   64'(hist[0].v));
    check("d1_memread",  64'(mr1),  64'(hist[0].mr));
    check("d1_rd",       64'(rd1),  64'(hist[0].rd));
    check("d1_data",     64'(d1),   64'(hist[0].d));
    check("d1_hazard",   64'(hz1),  64'(model_hazard(1, rs1, rs2)));
    check("d1_occ",      64'(occ1), 64'(model_occ(1)));
`ifdef MEM_PIPE_PERF_EN
    check("d2_stall_cnt", 64'(sc2), 64'(cnt_m));
`endif
  endtask

  task automatic step(input bit v, input bit mr, input bit rw, input bit [4:0] r,
                      input bit [31:0] d, input bit [4:0] a, input bit [4:0] b,
                      input bit st, input bit fl, input bit rn);
    ent_t e;
    @(negedge clk);
    valid = v; memread = mr; regwrite = rw; rd = r; data = d;
    rs1 = a; rs2 = b; stall = st; flush = fl; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      clear_model();
      cnt_m = 0;
    end else begin
      if (st && !fl && cnt_m != 32'hFFFF_FFFF) cnt_m++;
      if (fl) clear_model();
      else if (!st) begin
        e.v  = v;
        e.mr = v & mr;
        e.rw = v & rw;
        e.rd = v ? r : 5'd0;
        e.d  = v ? d : 32'd0;
        hist.push_front(e);
        void'(hist.pop_back());
      end
    end
    #1;
    check_all();
  endtask

  task automatic bubble();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    clear_model();
    cnt_m = 0;

    // Reset held two cycles while a valid input is offered.
    step(1, 1, 1, 5'd4, 32'h1234, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5'd4, 32'h1234, 0, 0, 0, 0, 0);
    check("rst_valid", 64'(v2), 64'd0);
    check("rst_rd",    64'(rd2), 64'd0);
    check("rst_occ",   64'(occ2), 64'd0);

    // Latency: load rd=5 then a second instruction, occupancy 1,2,1.
    step(1, 1, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
    check("lat_occ1", 64'(occ2), 64'd1);
    step(1, 0, 1, 5'd6, 32'h0000_0066, 0, 0, 0, 0, 1);
    check("lat_occ2", 64'(occ2), 64'd2);
    check("lat_valid", 64'(v2), 64'd1);
    check("lat_mr",    64'(mr2), 64'd1);
    check("lat_rd",    64'(rd2), 64'd5);
    check("lat_data",  64'(d2), 64'hDEAD_BEEF);
    bubble();
    check("lat_occ3", 64'(occ2), 64'd1);
    check("lat_rd6",  64'(rd2), 64'd6);

    // Stall: rd=7 inserted, three hold cycles, emerges at cycle 5.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 5'd8, 32'h88, 0, 0, 1, 0, 1);
      check("stall_frozen_valid", 64'(v2), 64'd0);
    end
    bubble();
    check("stall_rd7", 64'(rd2), 64'd7);
`ifdef MEM_PIPE_PERF_EN
    check("stall_cnt3", 64'(sc2), 64'd3);
`endif

    // Flush overrides stall and drops the input presented with it.
    step(1, 1, 1, 5'd1, 32'h11, 0, 0, 0, 0, 1);
    step(1, 1, 1, 5'd2, 32'h22, 0, 0, 0, 0, 1);
    step(1, 1, 1, 5'd9, 32'h99, 0, 0, 1, 1, 1);
    check("flush_occ",   64'(occ2), 64'd0);
    check("flush_valid", 64'(v2), 64'd0);
    bubble();
    check("flush_no9_a", 64'(rd2 == 5'd9), 64'd0);
    bubble();
    check("flush_no9_b", 64'(rd2 == 5'd9), 64'd0);

    // Hazard cases.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5'd3, 32'h3, 5'd1, 5'd3, 0, 0, 1);
    check("haz_load_rs2", 64'(hz2), 64'd1);
    step(0, 0, 0, 0, 0, 5'd3, 5'd0, 0, 0, 1);
    check("haz_stage1_rs1", 64'(hz2), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5'd3, 32'h3, 5'd1, 5'd3, 0, 0, 1);
    check("haz_no_load", 64'(hz2), 64'd0);
    step(1, 1, 1, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1);
    check("haz_x0", 64'(hz2), 64'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 49) != 0);
    end

`ifdef MEM_PIPE_PERF_EN
    // Saturation from one below the maximum.
    @(negedge clk);
    force u_dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.stall_cnt_q;
    cnt_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("sat_cnt", 64'(sc2), 64'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
